rr_mux_2_1: RTL and testbench

RR_MUX_2_1 -- requirements
Module: rr_mux_2_1

---
 rtl/sspt_pkg.sv | 32 +++
 rtl/rr_mux_2_1_if.sv | 43 ++++
 rtl/rr_mux_2_1_sync_fifo.sv | 70 +++++++
 rtl/rr_mux_2_1.sv | 108 ++++++++++
 tb/tb_rr_mux_2_1.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sspt_pkg.sv
// ---------------------------------------------------------------------------
// sspt_pkg -- shared definitions for the round-robin 2:1 merge.
//   ch_e      : channel identifier (CH0 = 0, CH1 = 1)
//   DW_DEF    : default channel data width
//   DEPTH_DEF : default per-channel FIFO depth
//   rr_pick() : round-robin channel choice from FIFO non-empty flags
// ---------------------------------------------------------------------------
package sspt_pkg;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } ch_e;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    // Tie goes to the channel not served last; otherwise the only
    // non-empty channel wins. With neither non-empty the result is unused.
    function automatic ch_e rr_pick(input logic ne0, input logic ne1, input ch_e last);
        ch_e pick;
        if (ne0 && ne1) begin
            pick = (last == CH0) ? CH1 : CH0;
        end else if (ne0) begin
            pick = CH0;
        end else begin
            pick = CH1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_mux_2_1_if.sv
// ---------------------------------------------------------------------------
// rr_mux_2_1_if -- handshake bundle of the 2:1 round-robin merge.
//   in0_data/in0_valid/in0_ready : channel-0 input (valid/ready)
//   in1_data/in1_valid/in1_ready : channel-1 input (valid/ready)
//   out_data/out_sel/out_valid/out_ready : merged output (valid/ready)
// Modports:
//   slave  : the merge block (consumes inputs, produces output)
//   master : the environment (produces inputs, consumes output)
// ---------------------------------------------------------------------------
interface rr_mux_2_1_if #(
    parameter int DW = sspt_pkg::DW_DEF
);

    logic [DW-1:0] in0_data;
    logic          in0_valid;
    logic          in0_ready;
    logic [DW-1:0] in1_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [DW-1:0] out_data;
    logic          out_sel;
    logic          out_valid;
    logic          out_ready;

    modport slave (
        input  in0_data, in0_valid,
        output in0_ready,
        input  in1_data, in1_valid,
        output in1_ready,
        output out_data, out_sel, out_valid,
        input  out_ready
    );

    modport master (
        output in0_data, in0_valid,
        input  in0_ready,
        output in1_data, in1_valid,
        input  in1_ready,
        input  out_data, out_sel, out_valid,
        output out_ready
    );

endinterface

// File: rtl/rr_mux_2_1_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO used as a per-channel input buffer.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write a word (ignored while full)
//   pop/rdata  : remove the head word (ignored while empty); rdata shows
//                the head combinationally
//   full/empty/count : occupancy, all derived from registered state
// Pointers wrap modulo DEPTH (power of 2); a DEPTH+1-valued count
// separates full from empty.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DW    = sspt_pkg::DW_DEF,
    parameter int DEPTH = sspt_pkg::DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage carries no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rr_mux_2_1.sv
// ---------------------------------------------------------------------------
// rr_mux_2_1 -- merges two buffered valid/ready channels into one
// registered output stream with round-robin arbitration.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset; clears FIFOs and output register
//   bus   : rr_mux_2_1_if.slave (in0_*, in1_*, out_*)
// The output register loads whenever it is free or being drained and a
// FIFO holds a word, giving one word per cycle under continuous out_ready.
// in*_ready comes only from FIFO occupancy, never from an input.
// ---------------------------------------------------------------------------
module rr_mux_2_1
    import sspt_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_mux_2_1_if.slave   bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] w_rdata0;
    logic [DW-1:0] w_rdata1;
    logic          w_full0;
    logic          w_full1;
    logic          w_empty0;
    logic          w_empty1;
    logic [CW-1:0] w_count0;
    logic [CW-1:0] w_count1;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop0;
    logic          w_pop1;
    logic          w_load;
    ch_e           w_pick;
    logic [DW-1:0] w_load_data;

    logic [DW-1:0] r_out_data;
    ch_e           r_out_sel;
    logic          r_out_valid;
    ch_e           r_last;

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push0),
        .wdata (bus.in0_data),
        .pop   (w_pop0),
        .rdata (w_rdata0),
        .full  (w_full0),
        .empty (w_empty0),
        .count (w_count0)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push1),
        .wdata (bus.in1_data),
        .pop   (w_pop1),
        .rdata (w_rdata1),
        .full  (w_full1),
        .empty (w_empty1),
        .count (w_count1)
    );

    assign bus.in0_ready = ~w_full0;
    assign bus.in1_ready = ~w_full1;
    assign w_push0       = bus.in0_valid & ~w_full0;
    assign w_push1       = bus.in1_valid & ~w_full1;

    always_comb begin
        w_load      = (~r_out_valid | bus.out_ready) & (~w_empty0 | ~w_empty1);
        w_pick      = rr_pick(~w_empty0, ~w_empty1, r_last);
        w_pop0      = w_load & (w_pick == CH0);
        w_pop1      = w_load & (w_pick == CH1);
        w_load_data = (w_pick == CH1) ? w_rdata1 : w_rdata0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= CH0;
            r_last      <= CH1;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_sel   <= w_pick;
            r_last      <= w_pick;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

    // Occupancy count and full flag must agree in both buffers.
    a_full0_count: assert property (@(posedge clk) disable iff (!rst_n)
        w_full0 == (w_count0 == CW'(DEPTH)));
    a_full1_count: assert property (@(posedge clk) disable iff (!rst_n)
        w_full1 == (w_count1 == CW'(DEPTH)));

endmodule

// File: tb/tb_rr_mux_2_1.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_2_1 -- self-checking bench for rr_mux_2_1.
// Stimulus pushes the hand-computed {sel, data} of every expected output
// into a queue; a monitor pops and compares on each output transfer.
// ---------------------------------------------------------------------------
module tb_rr_mux_2_1;
    import sspt_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_mux_2_1_if #(.DW(DW)) bus ();

    rr_mux_2_1 #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW:0] exp_q [$];

    int  n_acc     = 0;
    int  n_seen    = 0;
    int  acc_prev  = 0;
    bit  starve_on = 1'b0;
    bit  done      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves valid asserted so consecutive calls stream without bubbles.
    task automatic send(input bit ch, input logic [DW-1:0] d);
        logic rdy;
        if (ch) begin
            bus.in1_valid = 1'b1;
            bus.in1_data  = d;
        end else begin
            bus.in0_valid = 1'b1;
            bus.in0_data  = d;
        end
        for (int i = 0; i < 100; i++) begin
            rdy = ch ? bus.in1_ready : bus.in0_ready;
            tick();
            if (rdy) begin
                n_acc++;
                return;
            end
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic idle();
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
    endtask

    task automatic expect_word(input bit sel, input logic [DW-1:0] d);
        exp_q.push_back({sel, d});
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) begin
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // Monitor: one output transfer happens at the next rising edge when
    // out_valid && out_ready at the falling edge (inputs change only after
    // rising edges).
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n && starve_on && (acc_prev - n_seen) > 0) begin
            check("no_starve", bus.out_valid, 1);
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", {bus.out_sel, bus.out_data}, '1);
            end else begin
                e = exp_q.pop_front();
                check("out_word", {bus.out_sel, bus.out_data}, e);
            end
        end
    end

    always @(posedge clk) acc_prev = n_acc;

    initial begin
        bus.in0_valid = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data",  bus.out_data, 0);
        check("rst_out_sel",   bus.out_sel, 0);
        check("rst_in0_ready", bus.in0_ready, 1);
        check("rst_in1_ready", bus.in1_ready, 1);
        #10;
        rst_n = 1'b1;

        // Single word: accepted at edge 1, valid after edge 2 for one cycle
        bus.out_ready = 1'b1;
        expect_word(1'b0, 8'hA5);
        send(1'b0, 8'hA5);
        idle();
        check("single_lat_e1", bus.out_valid, 0);
        tick();
        check("single_valid_e2", bus.out_valid, 1);
        check("single_data_e2",  bus.out_data, 8'hA5);
        check("single_sel_e2",   bus.out_sel, 0);
        tick();
        check("single_one_cycle", bus.out_valid, 0);
        drain("drain_single", 10);

        // Fair tie
        do_reset();
        bus.out_ready = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_data = 8'h01;
        bus.in1_valid = 1'b1; bus.in1_data = 8'h81;
        tick();
        bus.in0_data = 8'h02;
        bus.in1_data = 8'h82;
        tick();
        idle();
        tick();
        check("tie_hold_valid", bus.out_valid, 1);
        check("tie_hold_data",  bus.out_data, 8'h01);
        expect_word(1'b0, 8'h01);
        expect_word(1'b1, 8'h81);
        expect_word(1'b0, 8'h02);
        expect_word(1'b1, 8'h82);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tie_consecutive", bus.out_valid, 1);
        end
        tick();
        check("tie_end_valid", bus.out_valid, 0);
        check("tie_queue_empty", exp_q.size(), 0);

        // Backpressure: 1 in output register + 4 in FIFO
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_word(1'b1, DW'(8'h30 + i));
            send(1'b1, DW'(8'h30 + i));
        end
        idle();
        check("bp_in1_ready", bus.in1_ready, 0);
        check("bp_in0_ready", bus.in0_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("bp_stable_valid", bus.out_valid, 1);
            check("bp_stable_data",  bus.out_data, 8'h30);
            check("bp_stable_sel",   bus.out_sel, 1);
            tick();
        end
        bus.out_ready = 1'b1;
        drain("drain_bp", 20);

        // Simultaneous push and pop: 16 words streamed with no gaps
        for (int i = 0; i < 16; i++) begin
            check("stream_in0_ready", bus.in0_ready, 1);
            expect_word(1'b0, DW'(8'h10 + i));
            send(1'b0, DW'(8'h10 + i));
            if (i >= 1) begin
                check("stream_no_gap", bus.out_valid, 1);
            end
        end
        idle();
        tick();
        check("stream_last_valid", bus.out_valid, 1);
        check("stream_last_data",  bus.out_data, 8'h1F);
        tick();
        check("stream_end_valid", bus.out_valid, 0);
        check("stream_queue_empty", exp_q.size(), 0);

        // Reset mid-stream: these four words must be discarded
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, DW'(8'h40 + i));
        end
        idle();
        check("mid_pre_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_data",  bus.out_data, 0);
        check("mid_rst_ready", bus.in0_ready, 1);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        expect_word(1'b1, 8'h55);
        send(1'b1, 8'h55);
        idle();
        drain("drain_mid", 10);
        for (int i = 0; i < 3; i++) tick();

        // Single active channel with random out_ready
        n_acc = 0;
        n_seen = 0;
        tick();
        starve_on = 1'b1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    expect_word(1'b1, DW'(8'h60 + i));
                    send(1'b1, DW'(8'h60 + i));
                end
                idle();
                done = 1'b1;
            end
            begin
                for (int i = 0; i < 300 && !(done && exp_q.size() == 0); i++) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        starve_on = 1'b0;
        bus.out_ready = 1'b1;
        drain("drain_random", 20);
        check("random_count", n_seen, 8);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
